// File: rtl/trace_capture_pkg.sv
// Shared types and default widths for the trace capture sequencer.
package trace_capture_pkg;

   localparam int unsigned TIME_W_DEF  = 64;
   localparam int unsigned CNT_W_DEF   = 10;
   localparam int unsigned STATE_W     = 3;

   // Capture sequencer states; encoding is visible on state_o.
   typedef enum logic [STATE_W-1:0] {
      IDLE = 3'd0,
      PRE  = 3'd1,
      WAIT = 3'd2,
      POST = 3'd3,
      DONE = 3'd4
   } trace_state_t;

endpackage

// File: rtl/trace_trig_detect.sv
// Strobe-qualified trigger edge detector.
// trig_in is only looked at on decimation strobes and compared with the value
// captured at the previous strobe. On arm the history is loaded with the level
// that cannot fire the selected edge, so the first post-arm strobe only fires
// on a genuine transition relative to that neutral level.
module trace_trig_detect (
   input  logic clk,
   input  logic rst,
   input  logic strobe,
   input  logic arm_init,
   input  logic trig_in,
   input  logic trig_fall,
   output logic edge_det
);

   logic hist;

   // History register: neutral level on arm, otherwise last strobed trig_in.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hist <= 1'b0;
      end else if (arm_init) begin
         hist <= trig_fall;
      end else if (strobe) begin
         hist <= trig_in;
      end
   end

   // Edge select: rising fires on 0->1, falling fires on 1->0.
   always_comb begin
      edge_det = strobe & (trig_fall ? (hist & ~trig_in) : (~hist & trig_in));
   end

endmodule

// File: rtl/trace_capture_ctrl.sv
// Trace capture sequencer: arm, decimated pre-trigger samples, trigger edge,
// fixed-length post-trigger run, stop.
// Optional build macro TRACE_CAPTURE_TIMESTAMP_EN adds the trig_time port,
// which latches emu_time on the trigger strobe and clears on arm.
//
// Sample handshake: a sample is offered when cap_valid is high and transfers
// on any clock edge where cap_valid and cap_ready are both high; cap_valid and
// the tags hold until that transfer. A strobe that finds a sample pending and
// not transferring in the same cycle is dropped and sets ovf.
module trace_capture_ctrl
   import trace_capture_pkg::*;
#(
   parameter int unsigned TIME_W = TIME_W_DEF,
   parameter int unsigned CNT_W  = CNT_W_DEF
) (
   input  logic              emu_clk,
   input  logic              emu_rst,
   input  logic              emu_dec_cmp,
   input  logic [TIME_W-1:0] emu_time,
   input  logic              arm,
   input  logic              abort,
   input  logic              trig_in,
   input  logic              trig_fall,
   input  logic [CNT_W-1:0]  pre_len,
   input  logic [CNT_W-1:0]  post_len,
   output logic              cap_valid,
   input  logic              cap_ready,
   output logic              cap_pre,
   output logic              cap_trig,
   output logic              cap_last,
   output logic [2:0]        state_o,
   output logic              busy,
   output logic              done,
   output logic              ovf
`ifdef TRACE_CAPTURE_TIMESTAMP_EN
   ,output logic [TIME_W-1:0] trig_time
`endif
);

   trace_state_t     state;
   logic [CNT_W-1:0] pre_cnt;
   logic [CNT_W-1:0] post_cnt;
   logic [CNT_W-1:0] pre_len_q;
   logic [CNT_W-1:0] post_len_q;
   logic [CNT_W-1:0] pre_cnt_inc;
   logic [CNT_W-1:0] post_cnt_inc;
   logic             hs;
   logic             slot_free;
   logic             arm_take;
   logic             edge_det;

   // Handshake qualifiers and saturating counter increments.
   always_comb begin
      hs           = cap_valid & cap_ready;
      slot_free    = ~cap_valid | cap_ready;
      arm_take     = arm & ~abort & ((state == IDLE) | (state == DONE));
      pre_cnt_inc  = (pre_cnt == '1)  ? pre_cnt  : pre_cnt + 1'b1;
      post_cnt_inc = (post_cnt == '1) ? post_cnt : post_cnt + 1'b1;
   end

   trace_trig_detect u_trig (
      .clk       (emu_clk),
      .rst       (emu_rst),
      .strobe    (emu_dec_cmp),
      .arm_init  (arm_take),
      .trig_in   (trig_in),
      .trig_fall (trig_fall),
      .edge_det  (edge_det)
   );

   // Sequencer FSM with registered sample strobe, tags and overflow flag.
   always_ff @(posedge emu_clk or posedge emu_rst) begin
      if (emu_rst) begin
         state      <= IDLE;
         cap_valid  <= 1'b0;
         cap_pre    <= 1'b0;
         cap_trig   <= 1'b0;
         cap_last   <= 1'b0;
         ovf        <= 1'b0;
         pre_cnt    <= '0;
         post_cnt   <= '0;
         pre_len_q  <= '0;
         post_len_q <= '0;
      end else begin
         if (hs) begin
            cap_valid <= 1'b0;
            cap_pre   <= 1'b0;
            cap_trig  <= 1'b0;
            cap_last  <= 1'b0;
         end
         if (abort) begin
            state     <= IDLE;
            cap_valid <= 1'b0;
            cap_pre   <= 1'b0;
            cap_trig  <= 1'b0;
            cap_last  <= 1'b0;
         end else begin
            case (state)
               IDLE, DONE: begin
                  if (arm) begin
                     ovf        <= 1'b0;
                     pre_cnt    <= '0;
                     post_cnt   <= '0;
                     pre_len_q  <= pre_len;
                     post_len_q <= (post_len == '0) ? CNT_W'(1) : post_len;
                     state      <= (pre_len == '0) ? WAIT : PRE;
                  end
               end
               PRE: begin
                  if (emu_dec_cmp) begin
                     if (slot_free) begin
                        cap_valid <= 1'b1;
                        cap_pre   <= 1'b1;
                        cap_trig  <= 1'b0;
                        cap_last  <= 1'b0;
                        pre_cnt   <= pre_cnt_inc;
                        if (pre_cnt_inc == pre_len_q) state <= WAIT;
                     end else begin
                        ovf <= 1'b1;
                     end
                  end
               end
               WAIT: begin
                  if (emu_dec_cmp) begin
                     if (slot_free) begin
                        cap_valid <= 1'b1;
                        cap_last  <= 1'b0;
                        if (edge_det) begin
                           cap_pre  <= 1'b0;
                           cap_trig <= 1'b1;
                           cap_last <= (post_len_q == CNT_W'(1));
                           post_cnt <= CNT_W'(1);
                           state    <= POST;
                        end else begin
                           cap_pre  <= 1'b1;
                           cap_trig <= 1'b0;
                        end
                     end else begin
                        ovf <= 1'b1;
                     end
                  end
               end
               POST: begin
                  if (hs && cap_last) state <= DONE;
                  // Strobes after the final sample has been emitted are ignored.
                  if (emu_dec_cmp && (post_cnt != post_len_q)) begin
                     if (slot_free) begin
                        cap_valid <= 1'b1;
                        cap_pre   <= 1'b0;
                        cap_trig  <= 1'b0;
                        cap_last  <= (post_cnt_inc == post_len_q);
                        post_cnt  <= post_cnt_inc;
                     end else begin
                        ovf <= 1'b1;
                     end
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

`ifdef TRACE_CAPTURE_TIMESTAMP_EN
   // Trigger timestamp: cleared on arm, captured on the accepted trigger strobe.
   always_ff @(posedge emu_clk or posedge emu_rst) begin
      if (emu_rst) begin
         trig_time <= '0;
      end else if (arm_take) begin
         trig_time <= '0;
      end else if (!abort && (state == WAIT) && emu_dec_cmp && slot_free && edge_det) begin
         trig_time <= emu_time;
      end
   end
`else
   logic unused_time;
   assign unused_time = ^emu_time;
`endif

   // Status decode from the registered state.
   always_comb begin
      state_o = state;
      busy    = (state != IDLE) && (state != DONE);
      done    = (state == DONE);
   end

endmodule

// File: doc/trace_capture_ctrl.md
# trace_capture_ctrl

Sequencer for emulator trace capture. It arms on command, emits decimated pre-trigger samples, waits for a trigger edge on a selected probe comparison, emits a fixed number of post-trigger samples, then stops. Each sample is a valid/ready strobe with tag bits to the downstream trace sample buffer. It sits between the emulator timebase (`emu_dec_cmp`, `emu_time`) and the trace port/ILA capture path.

## Interface
Parameters:
- `TIME_W`, 64: width of `emu_time` and `trig_time`.
- `CNT_W`, 10: width of `pre_len`, `post_len` and the internal sample counters.

Ports:
- `emu_clk` in 1: sole clock.
- `emu_rst` in 1: reset, asynchronous, active-high.
- `emu_dec_cmp` in 1: decimation strobe; a sample slot exists only in cycles where this is high.
- `emu_time` in `TIME_W`: current emulation time.
- `arm` in 1: one-cycle pulse that starts a capture.
- `abort` in 1: one-cycle pulse that cancels a capture.
- `trig_in` in 1: trigger condition level, e.g. a probe-threshold compare.
- `trig_fall` in 1: edge select; 0 = rising, 1 = falling.
- `pre_len` in `CNT_W`: number of guaranteed pre-trigger samples.
- `post_len` in `CNT_W`: number of post-trigger samples, trigger sample included.
- `cap_valid` out 1: sample strobe to the buffer.
- `cap_ready` in 1: buffer accepts the sample.
- `cap_pre` out 1: the sample is pre-trigger.
- `cap_trig` out 1: the sample is the trigger sample.
- `cap_last` out 1: the sample is the final sample.
- `state_o` out 3: current state encoding.
- `busy` out 1: state is neither IDLE nor DONE.
- `done` out 1: state is DONE.
- `ovf` out 1: sticky flag for a dropped sample.
- `trig_time` out `TIME_W`: latched trigger time; present only with the macro in Configuration.

## Operation
- States: IDLE, PRE, WAIT, POST, DONE.
- IDLE or DONE, on `arm`:
  - `pre_len` = 0: go to WAIT.
  - otherwise: go to PRE.
  - Arming clears `ovf` and the counters.
- `arm` while busy is ignored.
- PRE:
  - Each strobe emits one sample with `cap_pre`=1.
  - After `pre_len` strobes, go to WAIT.
  - Trigger edges in PRE are ignored, but the edge-history register still updates.
- WAIT:
  - Each strobe emits a sample with `cap_pre`=1; the downstream ring keeps the most recent samples.
  - A strobe on which an edge is detected emits the trigger sample (`cap_trig`=1, `cap_pre`=0), counts as post sample 1, and moves the state to POST.
- Edge detection:
  - `trig_in` is sampled only on strobes; it is compared with the value registered at the previous strobe.
  - Rising edge = prev 0 and current 1; falling edge = prev 1 and current 0, per `trig_fall`.
  - The history register resets to the value that does not fire an edge (0 for rising, 1 for falling), applied on arm.
- POST:
  - Each strobe emits a sample with both `cap_pre` and `cap_trig` at 0.
  - The sample that brings the post count to `post_len` carries `cap_last`=1.
  - `post_len` = 0 is treated as 1, so the trigger sample also carries `cap_last`.
- DONE is entered when the `cap_last` sample handshakes (`cap_valid` & `cap_ready`). The block stays in DONE until `arm`.
- Handshake:
  - `cap_valid` and the tag bits hold stable until `cap_ready`.
  - If a strobe arrives while a sample is pending and not accepted in that same cycle, the new sample is dropped. It is not counted, `ovf` is set, and any trigger edge on it is lost.
  - A handshake and a new strobe in the same cycle is not an overflow: the new sample replaces the old one.
- `abort`: go to IDLE on the next edge and deassert `cap_valid`. `abort` wins over a simultaneous `arm`.
- Counters saturate at `CNT_W` and never wrap. `pre_len` and `post_len` are sampled at `arm`; later changes have no effect on the running capture.

## Timing
- Reset values: state IDLE, all `cap_*` = 0, `busy`/`done`/`ovf` = 0, `trig_time` = 0.
- Latency: a strobe in cycle n produces `cap_valid` in cycle n+1 (registered outputs).
- The state change caused by a strobe, or by `arm`/`abort`, is visible in cycle n+1.
- `done` rises in the cycle after the handshake of the last sample.
- `emu_rst` asserted mid-capture forces IDLE asynchronously and discards the pending sample.

## Configuration
- `TRACE_CAPTURE_TIMESTAMP_EN` defined:
  - `trig_time` port exists.
  - It latches `emu_time` on the trigger strobe and holds until the next `arm`, which clears it to 0.
- Undefined: the port and its register are absent; behaviour is otherwise identical.

## Structure
- Package `trace_capture_pkg`: state enum `trace_state_t` (IDLE=0, PRE=1, WAIT=2, POST=3, DONE=4) and default width constants.
- Sub-module `trace_trig_detect`: strobe-qualified edge detector with edge select and arm-time history init.

## Test plan
- `pre_len`=3, `post_len`=4, `cap_ready`=1, rising edge on strobe 6 → 5 pre samples, trigger on the 6th, `cap_last` on the 9th sample, `done` one cycle after its handshake.
- `pre_len`=0, `post_len`=0, falling edge on the first post-arm strobe → a single sample with `cap_trig`=1 and `cap_last`=1.
- `cap_ready`=0 across 2 strobes → `cap_valid` held with stable tags, second sample dropped, `ovf`=1; the next `arm` clears `ovf`.
- `abort` in POST together with `arm` → IDLE next cycle, `cap_valid`=0, re-arm not taken.
- `emu_rst` pulsed in WAIT → immediate IDLE with all outputs at reset values; a subsequent normal capture completes.
- With `TRACE_CAPTURE_TIMESTAMP_EN`, trigger at `emu_time`=1000 → `trig_time`=1000 held through DONE, cleared to 0 on re-arm.
